// File: rtl/pressure_pkg.sv
// Shared definitions for the pressure-sensor sample path.
//   ADC_SAMPLE_WIDTH : native width of one ADC pressure sample
//   sample_t         : one ADC sample word
package pressure_pkg;

  localparam int unsigned ADC_SAMPLE_WIDTH = 12;

  typedef logic [ADC_SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/pressure_pipe_stage.sv
// One stage of the elastic sample pipeline: a data register plus its valid bit.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   flush        : clear valid, keep data
//   load         : capture data_in and mark valid
//   drain        : stage hands its sample on; clears valid unless load refills it
//   data_in      : incoming sample
//   data, valid  : registered stage contents
module pressure_pipe_stage
  import pressure_pkg::*;
#(
  parameter int unsigned      WIDTH       = ADC_SAMPLE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= RESET_VALUE;
      valid_q <= 1'b0;
    end else if (flush) begin
      // Flush drops samples but leaves the data word as-is.
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= data_in;
      valid_q <= 1'b1;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/pressure_pipe_reg.sv
// Elastic multi-stage register pipeline for pressure samples with valid/ready
// flow control, synchronous flush and true/complement outputs.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   flush               : drop every buffered sample (data registers keep contents)
//   in_valid, in_ready  : upstream handshake, d is the sample
//   out_valid, out_ready: downstream handshake, q is the last-stage data
//   q_n                 : bitwise complement of q
//   occupancy           : number of buffered samples; only present when
//                         PRESSURE_PIPE_OCCUPANCY_EN is defined
module pressure_pipe_reg
  import pressure_pkg::*;
#(
  parameter int unsigned      WIDTH       = ADC_SAMPLE_WIDTH,
  parameter int unsigned      DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH-1:0]             q_n
`ifdef PRESSURE_PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`endif
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pressure_pipe_reg: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] stage_in   [DEPTH];
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] load;
  logic             in_xfer;

  // Ready chain, evaluated from the output side back: a stage moves when the
  // stage after it is empty or is itself moving, so bubbles collapse at once.
  always_comb begin
    move            = '0;
    move[DEPTH-1]   = stage_valid[DEPTH-1] & out_ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      move[i] = stage_valid[i] & (~stage_valid[i+1] | move[i+1]);
    end
  end

  assign in_ready = ~stage_valid[0] | move[0];
  assign in_xfer  = in_valid & in_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign stage_in[g] = d;
      assign load[g]     = in_xfer;
    end else begin : g_body
      assign stage_in[g] = stage_data[g-1];
      assign load[g]     = move[g-1];
    end

    pressure_pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .load    (load[g]),
      .drain   (move[g]),
      .data_in (stage_in[g]),
      .data    (stage_data[g]),
      .valid   (stage_valid[g])
    );
  end

  assign out_valid = stage_valid[DEPTH-1];
  assign q         = stage_data[DEPTH-1];
  assign q_n       = ~stage_data[DEPTH-1];

`ifdef PRESSURE_PIPE_OCCUPANCY_EN
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [OccW-1:0] occ_q;
  logic [OccW-1:0] occ_d;
  logic            out_xfer;

  assign out_xfer = move[DEPTH-1];

  always_comb begin
    occ_d = occ_q;
    if (in_xfer && !out_xfer) begin
      occ_d = occ_q + 1'b1;
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule
